// File: rtl/spi_slave_ram_wrapper.sv
// SPI slave scratch RAM: select bit + 10-bit {cmd,payload} frames, MSB first.
// Define SPI_ADDR_AUTOINC_EN for post-access address auto-increment.
module spi_slave_ram_wrapper #(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_SIZE = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic MOSI,
   input  logic SS_n,
   output logic MISO
);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] CHK_CMD   = 3'd1;
   localparam logic [2:0] WRITE     = 3'd2;
   localparam logic [2:0] READ_ADD  = 3'd3;
   localparam logic [2:0] READ_DATA = 3'd4;

   logic [2:0]           r_state;
   logic [3:0]           r_rx_cnt;
   logic [8:0]           r_rx_shift;
   logic [9:0]           r_din;
   logic                 r_rx_valid;
   logic [ADDR_SIZE-1:0] r_wr_addr;
   logic [ADDR_SIZE-1:0] r_rd_addr;
   logic                 r_rd_seen;
   logic [7:0]           r_dout;
   logic                 r_tx_valid;
   logic [2:0]           r_tx_cnt;
   logic                 r_miso;
   logic [7:0]           r_mem [MEM_DEPTH];

   logic                 w_in_frame;
   logic                 w_shift_en;
   logic [1:0]           w_cmd;
   logic [ADDR_SIZE-1:0] w_addr;

   assign w_in_frame = (r_state == WRITE) || (r_state == READ_ADD) ||
                       (r_state == READ_DATA);
   assign w_shift_en = !SS_n && w_in_frame && (r_rx_cnt != 4'd10);
   assign w_cmd      = r_din[9:8];
   assign w_addr     = r_din[ADDR_SIZE-1:0];
   assign MISO       = r_miso;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else if (SS_n) begin
         r_state <= IDLE;
      end else begin
         unique case (r_state)
            IDLE:    r_state <= CHK_CMD;
            CHK_CMD: begin
               if (!MOSI)          r_state <= WRITE;
               else if (r_rd_seen) r_state <= READ_DATA;
               else                r_state <= READ_ADD;
            end
            WRITE, READ_ADD, READ_DATA: r_state <= r_state;
            default: r_state <= IDLE;
         endcase
      end
   end

   // Counter saturates at 10 so trailing bits are ignored until SS_n toggles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_cnt   <= '0;
         r_rx_shift <= '0;
         r_din      <= '0;
         r_rx_valid <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         if (SS_n) begin
            r_rx_cnt <= '0;
         end else if (w_shift_en) begin
            r_rx_shift <= {r_rx_shift[7:0], MOSI};
            r_rx_cnt   <= r_rx_cnt + 1'b1;
            if (r_rx_cnt == 4'd9) begin
               r_din      <= {r_rx_shift, MOSI};
               r_rx_valid <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_addr  <= '0;
         r_rd_addr  <= '0;
         r_rd_seen  <= 1'b0;
         r_dout     <= '0;
         r_tx_valid <= 1'b0;
         r_tx_cnt   <= '0;
         r_miso     <= 1'b0;
      end else begin
         if (SS_n) begin
            r_tx_valid <= 1'b0;
            r_tx_cnt   <= '0;
            r_miso     <= 1'b0;
         end else if (r_tx_valid) begin
            r_miso   <= r_dout[7];
            r_dout   <= {r_dout[6:0], 1'b0};
            r_tx_cnt <= r_tx_cnt + 1'b1;
            if (r_tx_cnt == 3'd7) r_tx_valid <= 1'b0;
         end else begin
            r_miso <= 1'b0;
         end
         if (r_rx_valid) begin
            unique case (w_cmd)
               2'b00: r_wr_addr <= w_addr;
               2'b01: begin
`ifdef SPI_ADDR_AUTOINC_EN
                  r_wr_addr <= r_wr_addr + 1'b1;
`else
                  r_wr_addr <= r_wr_addr;
`endif
               end
               2'b10: begin
                  r_rd_addr <= w_addr;
                  r_rd_seen <= 1'b1;
               end
               2'b11: begin
                  r_dout     <= r_mem[r_rd_addr];
                  r_tx_valid <= !SS_n;
                  r_tx_cnt   <= '0;
`ifdef SPI_ADDR_AUTOINC_EN
                  r_rd_addr  <= r_rd_addr + 1'b1;
`else
                  r_rd_seen  <= 1'b0;
`endif
               end
               default: r_rd_seen <= r_rd_seen;
            endcase
         end
      end
   end

   // RAM is deliberately left out of reset; contents survive rst.
   always_ff @(posedge clk) begin
      if (r_rx_valid && (w_cmd == 2'b01)) r_mem[r_wr_addr] <= r_din[7:0];
   end

endmodule

// File: tb/tb_spi_slave_ram_wrapper.sv
// Randomized self-checking bench for spi_slave_ram_wrapper.
// Reference model tracks RAM contents and address registers per frame.
module tb_spi_slave_ram_wrapper;

   logic clk = 1'b0;
   logic rst;
   logic MOSI;
   logic SS_n;
   logic MISO;

   int n_chk  = 0;
   int n_fail = 0;

   logic [7:0] m_mem [256];
   bit         m_known [256];
   int         m_wr;
   int         m_rd;
   logic [7:0] rd_byte;

   spi_slave_ram_wrapper #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
      .clk (clk),
      .rst (rst),
      .MOSI(MOSI),
      .SS_n(SS_n),
      .MISO(MISO)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_wr = 0;
      m_rd = 0;
   endtask

   task automatic model_apply(input logic [1:0] cmd, input logic [7:0] pl);
      case (cmd)
         2'd0: m_wr = int'(pl);
         2'd1: begin
            m_mem[m_wr]   = pl;
            m_known[m_wr] = 1'b1;
`ifdef SPI_ADDR_AUTOINC_EN
            m_wr = (m_wr + 1) % 256;
`endif
         end
         2'd2: m_rd = int'(pl);
         default: begin
`ifdef SPI_ADDR_AUTOINC_EN
            m_rd = (m_rd + 1) % 256;
`endif
         end
      endcase
   endtask

   // nbits < 10 aborts the frame by raising SS_n after that many data bits.
   task automatic run_frame(input logic sel, input logic [1:0] cmd,
                            input logic [7:0] pl, input int nbits);
      logic [9:0] f;
      logic [7:0] got;
      logic [7:0] exp;
      bit         kn;
      f = {cmd, pl};
      got = '0;
      @(negedge clk);
      SS_n = 1'b0;
      MOSI = 1'($urandom);
      @(negedge clk);
      MOSI = sel;
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk);
         MOSI = f[9-i];
      end
      @(negedge clk);
      MOSI = 1'($urandom);
      if (nbits < 10) begin
         SS_n = 1'b1;
         @(negedge clk);
         chk("abort_miso", MISO, 0);
         return;
      end
      @(negedge clk);
      chk("pre_miso", MISO, 0);
      if (cmd == 2'd3) begin
         exp = m_mem[m_rd];
         kn  = m_known[m_rd];
         for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            got  = {got[6:0], MISO};
            MOSI = 1'($urandom);
         end
         @(negedge clk);
         chk("post_miso", MISO, 0);
         rd_byte = got;
         if (kn) chk("rd_data", got, exp);
      end
      model_apply(cmd, pl);
      SS_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic reset_mid(input logic [1:0] cmd, input logic [7:0] pl,
                            input int k);
      logic [9:0] f;
      f = {cmd, pl};
      @(negedge clk);
      SS_n = 1'b0;
      MOSI = 1'($urandom);
      @(negedge clk);
      MOSI = 1'($urandom);
      for (int i = 0; i < k; i++) begin
         @(negedge clk);
         MOSI = f[9-i];
      end
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      chk("rst_miso", MISO, 0);
      SS_n = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      for (int a = 0; a < 256; a++) m_known[a] = 1'b0;
      model_reset();
      rst  = 1'b1;
      SS_n = 1'b1;
      MOSI = 1'b0;
      repeat (5) @(negedge clk);
      chk("reset_miso", MISO, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_miso", MISO, 0);

      run_frame(1'b0, 2'd0, 8'hFF, 10);
      run_frame(1'b0, 2'd1, 8'hAB, 10);
      run_frame(1'b1, 2'd2, 8'hFF, 10);
      run_frame(1'b1, 2'd3, 8'h5C, 10);
      chk("rd_FF", rd_byte, 8'hAB);

      run_frame(1'b0, 2'd0, 8'h00, 10);
      run_frame(1'b0, 2'd1, 8'h44, 10);
      rst = 1'b1;
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      run_frame(1'b1, 2'd3, 8'h00, 10);
      chk("rd_noaddr_00", rd_byte, 8'h44);
      run_frame(1'b1, 2'd2, 8'h00, 10);
      run_frame(1'b1, 2'd3, 8'h99, 10);
`ifndef SPI_ADDR_AUTOINC_EN
      chk("rd_00", rd_byte, 8'h44);
`endif

      run_frame(1'b0, 2'd0, 8'h10, 10);
      run_frame(1'b0, 2'd1, 8'h5A, 10);
      run_frame(1'b0, 2'd0, 8'h10, 10);
      run_frame(1'b0, 2'd1, 8'hC3, 5);
      run_frame(1'b1, 2'd2, 8'h10, 10);
      run_frame(1'b1, 2'd3, 8'h00, 10);
      chk("abort_keep", rd_byte, 8'h5A);

      reset_mid(2'd1, 8'hEE, 10);
      run_frame(1'b1, 2'd2, 8'h00, 10);
      run_frame(1'b1, 2'd3, 8'h00, 10);
      chk("rst_mid_keep", rd_byte, 8'h44);

      for (int a = 0; a < 256; a++) begin
         run_frame(1'($urandom), 2'd0, 8'(a), 10);
         run_frame(1'($urandom), 2'd1, 8'($urandom), 10);
      end

      for (int n = 0; n < 400; n++) begin
         int r;
         r = $urandom_range(0, 9);
         if (r < 8)
            run_frame(1'($urandom), 2'(r / 2), 8'($urandom), 10);
         else if (r == 8)
            run_frame(1'($urandom), 2'($urandom), 8'($urandom),
                      $urandom_range(0, 9));
         else
            reset_mid(2'($urandom), 8'($urandom), $urandom_range(0, 10));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/spi_slave_ram_wrapper.md
Name: spi_slave_ram_wrapper

Overview:
SPI slave (mode-0 style, sampled on clk) bridged to a single-port synchronous RAM. The master sends 1 select bit and then a 10-bit frame, {cmd[1:0], payload[7:0]}, to set the write address, write data, set the read address, or fetch read data. Read data returns serially on MISO. The block sits at the SoC edge as a simple SPI-accessible scratch memory.

Parameters:
MEM_DEPTH, 256, number of RAM words (8-bit each)
ADDR_SIZE, 8, address width; MEM_DEPTH = 2**ADDR_SIZE

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  reset, asynchronous, active-high
MOSI  input  1  serial data from master, MSB first
SS_n  input  1  slave select, active-low; high aborts any frame
MISO  output  1  serial read data to master, MSB first

Behaviour:
- Reset (rst=1, async): FSM=IDLE, bit counters=0, write/read address regs=0, rd_addr_seen=0, rx_valid=0, tx_valid=0, MISO=0. RAM contents are NOT cleared.
- FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA. SS_n=1 in any state -> IDLE next edge, counters cleared, MISO=0.
- IDLE: SS_n=0 -> CHK_CMD.
- CHK_CMD: sample MOSI. 0 -> WRITE. 1 -> READ_DATA if rd_addr_seen=1, else READ_ADD.
- WRITE/READ_ADD/READ_DATA: shift MOSI into 10-bit rx register MSB first, one bit per clk. On the 10th bit, pulse rx_valid for 1 cycle with din[9:0].
- RAM decode on rx_valid (acts next edge):
  - din[9:8]=00: wr_addr<=din[7:0]
  - 01: mem[wr_addr]<=din[7:0]
  - 10: rd_addr<=din[7:0]; rd_addr_seen<=1
  - 11: dout<=mem[rd_addr]; tx_valid<=1; rd_addr_seen<=0
- A cmd that does not match the state (e.g. 1x in WRITE) is still decoded per the above. The state only steers the entry path.
- READ_DATA readout: the cycle after tx_valid rises, drive dout[7] on MISO, then dout[6]..dout[0] on successive clks (8 cycles). Hold MISO=0 afterwards. tx_valid clears when the 8th bit is shifted or SS_n rises. Remain in READ_DATA until SS_n=1.
- MISO=0 whenever not shifting read data.
- Extra MOSI bits after the 10th are ignored until SS_n toggles.
- Reset mid-frame: frame discarded, no RAM write.

Optional Feature:
SPI_ADDR_AUTOINC_EN: when defined, wr_addr increments (mod MEM_DEPTH) after each cmd 01 write, and rd_addr increments after each cmd 11 fetch. In that mode rd_addr_seen stays set after cmd 11, so consecutive reads need no new read address. When undefined, addresses are static and rd_addr_seen clears after cmd 11, as above.

Test Plan:
- Reset: rst=1 for 5 clks -> MISO=0, state IDLE; preloaded mem values unchanged.
- Write: frame 0+00_11111111, then frame 0+01_10101011 -> mem[0xFF]=0xAB after rx_valid+1.
- Read: frame 1+10_11111111, then frame 1+11_xxxxxxxx -> tx_valid=1, MISO shows 1,0,1,0,1,0,1,1 over the next 8 clks.
- Address 0 path: write 0x44 to 0x00, reset, read 0x00 -> MISO=0x44 (memory survives reset).
- Abort: SS_n=1 after 5 data bits of a write-data frame -> no RAM change; FSM IDLE the next clk.
- Read without address: rd_addr_seen=0, MOSI select bit=1 -> FSM enters READ_ADD (not READ_DATA).
